valid_ready_pipeline: RTL and testbench
=======================================

// Module: valid_ready_pipeline
// PURPOSE
//   Multi-stage, fully registered valid/ready pipeline carrying a WIDTH-bit value.
//   Each stage adds 1 (mod 2**WIDTH), so every accepted word leaves as input_val + STAGES.
//   Each stage is a two-entry skid slice: full throughput, no combinational ready path.
//   Sits between a producer and a consumer in the pipeFlow datapath as a flow-controlled delay.
// PARAMETERS
//   WIDTH   5  data width of input_val/output_val
//   STAGES  3  number of register stages (>=1); latency and increment amount
// PORTS
//   clk_i         in   1      single clock; all logic on rising edge
//   reset_i       in   1      synchronous, active-high reset
//   input_val     in   WIDTH  upstream data
//   input_valid   in   1      upstream data valid
//   input_rdy     out  1      pipeline can accept a word this cycle
//   output_val    out  WIDTH  downstream data
//   output_valid  out  1      output_val holds a valid word
//   output_rdy    in   1      downstream accepts a word this cycle
// BEHAVIOUR
//   - Clock/reset: one clock, clk_i; reset_i is synchronous and active-high.
//   - Transfer rule: a transfer happens on a rising edge when valid && rdy on that
//     interface. Input transfer: input_valid && input_rdy. Output transfer:
//     output_valid && output_rdy.
//   - Reset (reset_i=1 at a rising edge): every stage is emptied.
//     Reset values: output_valid=0, output_val=0, input_rdy=0 while reset_i=1.
//     input_rdy=1 on the first cycle after reset is released.
//     A reset asserted mid-operation discards all in-flight words, which never appear
//     at the output.
//   - Stage k (k=0..STAGES-1) holds a main register and a skid register, each with its
//     own valid bit.
//     - Stage rdy_out = skid register empty (registered signal).
//     - When the stage accepts a word, it stores in_data+1 (mod 2**WIDTH): into main if
//       main is empty or being drained this cycle, otherwise into skid.
//     - When main drains, skid (if valid) moves into main.
//   - Chaining: stage 0 takes its input from input_val/input_valid and drives
//     input_rdy. The last stage drives output_val/output_valid and uses output_rdy.
//   - Latency: with output_rdy=1, a word accepted at edge N has output_valid=1 after
//     edge N+STAGES-1 and transfers at edge N+STAGES. Throughput is 1 word/cycle.
//   - Ordering: words leave in strict FIFO order; none are duplicated or dropped.
//     Bubbles are not compressed beyond the stalls that occur.
//   - Backpressure:
//     - While output_rdy=0, output_valid/output_val hold stable until the transfer.
//     - Capacity is 2*STAGES words.
//     - input_rdy falls once stage 0's skid register fills, always on a registered edge.
//   - Input side: input_val is ignored when input_valid=0. A word offered with
//     input_rdy=0 is not taken; upstream must hold it.
//   - Simultaneous fill/drain: a stage may accept and emit in the same cycle with no
//     loss of a slot.
//   - Arithmetic: the increment wraps, so 31 + 1 = 0 for WIDTH=5.
//   - Output_val is 0 whenever output_valid=0 after reset; it is not required to
//     hold stale data.
// TESTING
//   1) Reset: hold reset_i=1 for 2 cycles with input_valid=1 -> output_valid=0,
//      input_rdy=0, and no word is captured.
//   2) Single word: input_val=0 with input_valid=1 for one cycle, output_rdy=1 ->
//      output_val=3 with output_valid high for exactly one cycle, 3 edges after
//      acceptance.
//   3) Streaming: input_val=0..9 back-to-back, output_rdy=1 -> outputs 3..12 on
//      consecutive cycles with no gaps.
//   4) Wrap: input_val=30 and 31 -> output_val=1 then 2.
//   5) Backpressure: stream 0..9 with output_rdy=0 -> input_rdy drops after 6 words,
//      and output holds at 3. Then set output_rdy=1 -> 3..12 emerge in order, with
//      no loss or duplication.
//   6) Mid-stream reset: assert reset_i for one cycle while 4 words are in flight ->
//      none of them appear at the output, and a new input 5 then yields 8.

Source files
------------

// File: rtl/valid_ready_pipeline.sv
// STAGES-deep valid/ready pipeline of two-entry skid slices; each slice adds 1 to the word.
// Ready is taken from skid occupancy only, so no combinational path runs from output_rdy to input_rdy.

module vr_stage #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_rdy
);
    logic [WIDTH-1:0] main_q, skid_q, inc;
    logic             main_vld, skid_vld;
    logic             in_fire, main_free;

    assign inc       = in_data + WIDTH'(1);
    // Masked during reset so upstream never sees ready while the slice is being flushed.
    assign in_rdy    = ~skid_vld & ~rst;
    assign in_fire   = in_valid & in_rdy;
    assign main_free = ~main_vld | out_rdy;
    assign out_data  = main_q;
    assign out_valid = main_vld;

    // skid_vld implies main_vld and blocks in_fire, so a refill from skid never races a new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= '0;
            main_vld <= 1'b0;
            skid_q   <= '0;
            skid_vld <= 1'b0;
        end else if (main_free) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_q   <= '0;
                skid_vld <= 1'b0;
            end else if (in_fire) begin
                main_q   <= inc;
                main_vld <= 1'b1;
            end else begin
                main_q   <= '0;
                main_vld <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q   <= inc;
            skid_vld <= 1'b1;
        end
    end
endmodule

module valid_ready_pipeline #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] input_val,
    input  logic             input_valid,
    output logic             input_rdy,
    output logic [WIDTH-1:0] output_val,
    output logic             output_valid,
    input  logic             output_rdy
);
    // Index k is the link feeding stage k; index STAGES is the pipeline output.
    logic [STAGES:0][WIDTH-1:0] data;
    logic [STAGES:0]            vld;
    logic [STAGES:0]            rdy;

    assign data[0]      = input_val;
    assign vld[0]       = input_valid;
    assign input_rdy    = rdy[0];
    assign output_val   = data[STAGES];
    assign output_valid = vld[STAGES];
    assign rdy[STAGES]  = output_rdy;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        vr_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk_i),
            .rst       (reset_i),
            .in_data   (data[k]),
            .in_valid  (vld[k]),
            .in_rdy    (rdy[k]),
            .out_data  (data[k+1]),
            .out_valid (vld[k+1]),
            .out_rdy   (rdy[k+1])
        );
    end
endmodule

// File: tb/tb_valid_ready_pipeline.sv
// Directed bench for valid_ready_pipeline (WIDTH=5, STAGES=3): latency, streaming, wrap,
// backpressure and mid-stream reset, with hand-computed expectations.
module tb_valid_ready_pipeline;
    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [4:0] input_val;
    logic       input_valid;
    logic       input_rdy;
    logic [4:0] output_val;
    logic       output_valid;
    logic       output_rdy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int in_acc  = 0;
    int oq[$];
    int cq[$];
    int nxt, last;

    valid_ready_pipeline #(.WIDTH(5), .STAGES(3)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .input_val    (input_val),
        .input_valid  (input_valid),
        .input_rdy    (input_rdy),
        .output_val   (output_val),
        .output_valid (output_valid),
        .output_rdy   (output_rdy)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 ns after posedge, so negedge values are what the next edge samples.
    always @(negedge clk_i) begin
        cyc++;
        if (input_valid === 1'b1 && input_rdy === 1'b1) in_acc++;
        if (reset_i === 1'b0 && output_valid === 1'b1 && output_rdy === 1'b1) begin
            oq.push_back(int'(output_val));
            cq.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of a producer that offers nxt..last and holds each word until accepted.
    task automatic cycle();
        logic rdy_b;
        if (nxt <= last) begin
            input_valid = 1'b1;
            input_val   = 5'(nxt);
        end else begin
            input_valid = 1'b0;
            input_val   = 5'd0;
        end
        rdy_b = input_rdy;
        @(posedge clk_i); #1;
        if (input_valid && rdy_b) nxt++;
    endtask

    task automatic idle(input int n);
        nxt = 1; last = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic int q_at(input int i);
        return (i < oq.size()) ? oq[i] : -1;
    endfunction

    initial begin
        reset_i = 1'b1; input_valid = 1'b1; input_val = 5'd7; output_rdy = 1'b1;
        nxt = 1; last = 0;

        // Reset held two cycles with a word offered
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i); #1;
            chk("rst_ovalid", int'(output_valid), 0);
            chk("rst_irdy", int'(input_rdy), 0);
        end
        chk("rst_oval", int'(output_val), 0);
        reset_i = 1'b0; input_valid = 1'b0;
        #1;
        chk("rst_rdy_after", int'(input_rdy), 1);
        chk("rst_no_capture", in_acc, 0);
        idle(4);
        chk("rst_no_output", oq.size(), 0);

        // Single word: 0 -> 3, valid for exactly one cycle
        oq.delete(); cq.delete();
        nxt = 0; last = 0;
        cycle();
        chk("single_acc", nxt, 1);
        nxt = 1; last = 0;
        cycle(); chk("single_v1", int'(output_valid), 0);
        cycle(); chk("single_v2", int'(output_valid), 1);
        chk("single_val", int'(output_val), 3);
        cycle(); chk("single_v3", int'(output_valid), 0);
        chk("single_v3_val", int'(output_val), 0);
        idle(2);
        chk("single_count", oq.size(), 1);
        chk("single_q", q_at(0), 3);

        // Back-to-back stream 0..9
        oq.delete(); cq.delete();
        nxt = 0; last = 9;
        for (int i = 0; i < 10; i++) cycle();
        chk("stream_acc", nxt, 10);
        idle(6);
        chk("stream_count", oq.size(), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("stream_%0d", i), q_at(i), i + 3);
        if (cq.size() == 10) chk("stream_gapless", cq[9] - cq[0], 9);
        else chk("stream_gapless", cq.size(), 10);

        // Wrap: 30 -> 1, 31 -> 2
        oq.delete(); cq.delete();
        nxt = 30; last = 31;
        cycle(); cycle();
        idle(5);
        chk("wrap_count", oq.size(), 2);
        chk("wrap_0", q_at(0), 1);
        chk("wrap_1", q_at(1), 2);

        // Backpressure: capacity 6, output holds, then drains in order
        oq.delete(); cq.delete();
        output_rdy = 1'b0;
        nxt = 0; last = 9;
        for (int i = 0; i < 12; i++) cycle();
        chk("bp_accepted", nxt, 6);
        chk("bp_irdy", int'(input_rdy), 0);
        chk("bp_ovalid", int'(output_valid), 1);
        chk("bp_oval", int'(output_val), 3);
        for (int i = 0; i < 3; i++) cycle();
        chk("bp_hold_val", int'(output_val), 3);
        chk("bp_hold_valid", int'(output_valid), 1);
        chk("bp_no_output", oq.size(), 0);
        output_rdy = 1'b1;
        for (int i = 0; i < 40 && nxt <= last; i++) cycle();
        chk("bp_budget", nxt, 10);
        idle(10);
        chk("bp_count", oq.size(), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("bp_%0d", i), q_at(i), i + 3);

        // Mid-stream reset discards in-flight words
        oq.delete(); cq.delete();
        output_rdy = 1'b0;
        nxt = 20; last = 23;
        for (int i = 0; i < 4; i++) cycle();
        chk("mrst_acc", nxt, 24);
        input_valid = 1'b0;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        chk("mrst_ovalid", int'(output_valid), 0);
        output_rdy = 1'b1;
        nxt = 5; last = 5;
        cycle();
        idle(6);
        chk("mrst_count", oq.size(), 1);
        chk("mrst_val", q_at(0), 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
